// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width, signed sample and stereo pair.
package audio_pkg;
    localparam int AUDIO_DATA_W = 24;

    typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t left;
        audio_sample_t right;
    } stereo_frame_t;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S master clock generator: divides clk into BCLK, tracks the frame bit
// position and produces LRCLK plus fall_evt / frame_load strobes.
module i2s_clkgen #(
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic i2s_bclk,
    output logic i2s_lrclk,
    output logic fall_evt,
    output logic frame_load
);
    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int FW = $clog2(2 * SLOT_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2 - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(2 * SLOT_W - 1);
    localparam logic [FW-1:0] F_RIGHT  = FW'(SLOT_W);

    logic [DW-1:0] div_cnt;
    logic [FW-1:0] f_cnt;
    logic [FW-1:0] f_next;

    assign fall_evt   = enable && (div_cnt == DIV_LAST);
    assign frame_load = fall_evt && (f_cnt == '0);
    assign f_next     = (f_cnt == F_LAST) ? '0 : f_cnt + FW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            f_cnt     <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
        end else if (!enable) begin
            div_cnt   <= '0;
            f_cnt     <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            if (div_cnt == DIV_HALF) begin
                i2s_bclk <= 1'b1;
            end else if (fall_evt) begin
                i2s_bclk <= 1'b0;
            end
            // LRCLK follows the new bit position, so it leads the slot MSB by one BCLK.
            if (fall_evt) begin
                f_cnt     <= f_next;
                i2s_lrclk <= (f_next >= F_RIGHT);
            end
        end
    end
endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter with a one-frame pending buffer and underrun flag.
// Optional I2S_TX_UNDERRUN_HOLD_EN: an underrun repeats the last loaded pair.
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic signed [DATA_W-1:0] sample_left,
    input  logic signed [DATA_W-1:0] sample_right,
    output logic                     i2s_bclk,
    output logic                     i2s_lrclk,
    output logic                     i2s_sdata,
    output logic                     underrun
);
    localparam int FRAME_W = 2 * SLOT_W;

    logic               fall_evt;
    logic               frame_load;
    logic               pend_valid;
    logic [DATA_W-1:0]  pend_l;
    logic [DATA_W-1:0]  pend_r;
    logic [DATA_W-1:0]  fill_l;
    logic [DATA_W-1:0]  fill_r;
    logic [DATA_W-1:0]  load_l;
    logic [DATA_W-1:0]  load_r;
    logic [FRAME_W-1:0] load_word;
    logic [FRAME_W-1:0] shreg;
    logic               xfer;

    i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .fall_evt   (fall_evt),
        .frame_load (frame_load)
    );

    // Handshake: a pair transfers on any clk edge where sample_valid and
    // sample_ready are both high; ready is simply "pending buffer empty".
    assign sample_ready = !pend_valid;
    assign xfer         = sample_valid && sample_ready;
    assign underrun     = frame_load && !pend_valid;
    assign i2s_sdata    = shreg[FRAME_W-1];

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    logic [DATA_W-1:0] last_l;
    logic [DATA_W-1:0] last_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_l <= '0;
            last_r <= '0;
        end else if (frame_load) begin
            last_l <= load_l;
            last_r <= load_r;
        end
    end

    assign fill_l = last_l;
    assign fill_r = last_r;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif

    always_comb begin
        load_l    = pend_valid ? pend_l : fill_l;
        load_r    = pend_valid ? pend_r : fill_r;
        load_word = '0;
        load_word[FRAME_W-1 -: DATA_W] = load_l;
        load_word[SLOT_W-1  -: DATA_W] = load_r;
    end

    // A transfer only happens with pending empty, so a coincident load is the underrun case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_l     <= '0;
            pend_r     <= '0;
        end else if (xfer) begin
            pend_valid <= 1'b1;
            pend_l     <= sample_left;
            pend_r     <= sample_right;
        end else if (frame_load) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (!enable) begin
            shreg <= '0;
        end else if (frame_load) begin
            shreg <= load_word;
        end else if (fall_evt) begin
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: an I2S receiver decodes frames at
// BCLK rising edges and each phase compares them against hand-picked pairs.
module tb_i2s_tx_serializer;
    localparam int DATA_W    = 24;
    localparam int SLOT_W    = 32;
    localparam int BCLK_DIV  = 4;
    localparam int FRAME_CLK = 2 * SLOT_W * BCLK_DIV;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              sample_valid;
    logic              sample_ready;
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_sdata;
    logic              underrun;

    int checks = 0;
    int errors = 0;
    int ur_cnt = 0;

    i2s_tx_serializer #(
        .DATA_W   (DATA_W),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // receiver: samples SD/WS at each BCLK rise, bit 0 of a frame is f=0
    logic              bclk_q = 1'b0;
    int                bit_idx = 0;
    logic              rx_sd[64];
    logic              rx_ws[64];
    logic [63:0]       last_rise = 0;
    logic [63:0]       bclk_period = 0;
    logic [DATA_W-1:0] rx_l_q[$];
    logic [DATA_W-1:0] rx_r_q[$];
    logic              rx_pad_q[$];
    logic              rx_lr_q[$];

    always @(negedge clk) begin : rx
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        logic              pad;
        logic              lr_ok;
        if (underrun) ur_cnt++;
        if (!rst_n || !enable) begin
            bit_idx   = 0;
            last_rise = 0;
        end else if (i2s_bclk && !bclk_q) begin
            if (last_rise != 0) bclk_period = $time - last_rise;
            last_rise        = $time;
            rx_sd[bit_idx]   = i2s_sdata;
            rx_ws[bit_idx]   = i2s_lrclk;
            bit_idx++;
            if (bit_idx == 64) begin
                l = '0; r = '0; pad = rx_sd[0]; lr_ok = 1'b1;
                for (int i = 1; i <= DATA_W; i++) l = {l[DATA_W-2:0], rx_sd[i]};
                for (int i = SLOT_W + 1; i <= SLOT_W + DATA_W; i++) r = {r[DATA_W-2:0], rx_sd[i]};
                for (int i = DATA_W + 1; i <= SLOT_W; i++) pad = pad | rx_sd[i];
                for (int i = SLOT_W + DATA_W + 1; i < 64; i++) pad = pad | rx_sd[i];
                for (int i = 0; i < 64; i++) if (rx_ws[i] != (i >= SLOT_W)) lr_ok = 1'b0;
                rx_l_q.push_back(l);
                rx_r_q.push_back(r);
                rx_pad_q.push_back(pad);
                rx_lr_q.push_back(lr_ok);
                bit_idx = 0;
            end
        end
        bclk_q = i2s_bclk;
    end

    // driver tasks
    task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int cyc = 0;
        @(negedge clk);
        while (!sample_ready && cyc < 2 * FRAME_CLK) begin
            @(negedge clk);
            cyc++;
        end
        check("send_ready", 64'(sample_ready), 64'd1);
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int cyc = 0;
        while (rx_l_q.size() < n && cyc < (n + 2) * FRAME_CLK) begin
            @(negedge clk);
            cyc++;
        end
        if (rx_l_q.size() < n) check({tag, "_timeout"}, 64'(rx_l_q.size()), 64'(n));
    endtask

    task automatic wait_bit(input int idx);
        int cyc = 0;
        @(negedge clk);
        while (bit_idx != idx && cyc < 2 * FRAME_CLK) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_bit", 64'(bit_idx), 64'(idx));
    endtask

    task automatic check_frame(input string tag, input logic [DATA_W-1:0] el, input logic [DATA_W-1:0] er);
        if (rx_l_q.size() == 0) begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_left"},  64'(rx_l_q.pop_front()),   64'(el));
            check({tag, "_right"}, 64'(rx_r_q.pop_front()),   64'(er));
            check({tag, "_pad"},   64'(rx_pad_q.pop_front()), 64'd0);
            check({tag, "_lrclk"}, 64'(rx_lr_q.pop_front()),  64'd1);
        end
    endtask

    task automatic stop_link();
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rx_l_q.delete();
        rx_r_q.delete();
        rx_pad_q.delete();
        rx_lr_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"},     64'(i2s_bclk),     64'd0);
        check({tag, "_lrclk"},    64'(i2s_lrclk),    64'd0);
        check({tag, "_sdata"},    64'(i2s_sdata),    64'd0);
        check({tag, "_underrun"}, 64'(underrun),     64'd0);
        check({tag, "_ready"},    64'(sample_ready), 64'd1);
    endtask

    // scoreboard for the streaming phase
    logic [2*DATA_W-1:0] exp_q[$];

    initial begin
        int                base;
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        logic [2*DATA_W-1:0] e;

        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
        sample_left = '0; sample_right = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // single frame, sample queued before the first load
        send_pair(24'h800001, 24'h7FFFFE);
        check("ready_after_xfer", 64'(sample_ready), 64'd0);
        base = ur_cnt;
        @(negedge clk);
        enable = 1'b1;
        wait_frames(1, "single");
        check("ready_after_load", 64'(sample_ready), 64'd1);
        check("bclk_period", bclk_period, 64'd40);
        check_frame("single", 24'h800001, 24'h7FFFFE);

        // second frame has no sample: one underrun
        wait_frames(1, "underrun");
        check("underrun_once", 64'(ur_cnt - base), 64'd1);
        check_frame("underrun", HOLD ? 24'h800001 : 24'h0, HOLD ? 24'h7FFFFE : 24'h0);
        stop_link();

        // transfer coincides with the first load while pending is empty
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample_left = 24'h123456; sample_right = 24'hFEDCBA; sample_valid = 1'b1;
        check("sim_underrun", 64'(underrun), 64'd1);
        check("sim_ready", 64'(sample_ready), 64'd1);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        check("sim_pending", 64'(sample_ready), 64'd0);
        wait_frames(2, "sim");
        check_frame("sim_f0", HOLD ? 24'h800001 : 24'h0, HOLD ? 24'h7FFFFE : 24'h0);
        check_frame("sim_f1", 24'h123456, 24'hFEDCBA);
        stop_link();

        // back-to-back stream of 100 frames
        base = ur_cnt;
        exp_q.delete();
        for (int k = 0; k < 100; k++) begin
            l = 24'(k * 32'h010307 + 32'h5A);
            r = 24'(32'hFFFFFF - k * 32'h000911);
            send_pair(l, r);
            check($sformatf("stream_ready_low_%0d", k), 64'(sample_ready), 64'd0);
            exp_q.push_back({l, r});
            if (k == 0) enable = 1'b1;
        end
        wait_frames(100, "stream");
        check("stream_no_underrun", 64'(ur_cnt - base), 64'd0);
        for (int k = 0; k < 100; k++) begin
            e = exp_q.pop_front();
            check_frame($sformatf("stream_%0d", k), e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
        stop_link();

        // enable dropped mid-frame with a sample pending, then restored
        send_pair(24'h0F0F0F, 24'hF0F0F0);
        enable = 1'b1;
        send_pair(24'h000001, 24'hFFFFFF);
        wait_bit(10);
        enable = 1'b0;
        @(negedge clk);
        check("dis_bclk",  64'(i2s_bclk),     64'd0);
        check("dis_lrclk", 64'(i2s_lrclk),    64'd0);
        check("dis_sdata", 64'(i2s_sdata),    64'd0);
        check("dis_ready", 64'(sample_ready), 64'd0);
        repeat (20) @(negedge clk);
        check("dis_hold_sdata", 64'(i2s_sdata), 64'd0);
        rx_l_q.delete(); rx_r_q.delete(); rx_pad_q.delete(); rx_lr_q.delete();
        enable = 1'b1;
        wait_frames(1, "restart");
        check_frame("restart", 24'h000001, 24'hFFFFFF);
        check("restart_ready", 64'(sample_ready), 64'd1);

        // asynchronous reset mid-frame with a sample pending
        send_pair(24'h55AA55, 24'hAA55AA);
        send_pair(24'h13579B, 24'h2468AC);
        wait_bit(40);
        check("pre_reset_ready", 64'(sample_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Output end of the equalizer audio path. Accepts filtered 24-bit stereo sample pairs through a valid/ready handshake and serializes them onto a standard Philips I2S link to the DAC.
- Generates BCLK and LRCLK as master from the system clock by integer division.
- Holds one pending stereo frame so the filter side can deliver a sample anywhere within the current frame period.

Parameters:
- DATA_W, 24, sample width in bits, signed two's complement; must satisfy DATA_W <= SLOT_W.
- SLOT_W, 32, BCLK periods per channel slot; a frame is 2*SLOT_W bits.
- BCLK_DIV, 4, clk cycles per BCLK period; even, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  link run; when low, the serializer idles.
- sample_valid  in  1  sample_left/sample_right valid.
- sample_ready  out  1  pending buffer empty; a transfer occurs when valid and ready are both high.
- sample_left  in  DATA_W  left sample, signed.
- sample_right  in  DATA_W  right sample, signed.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- underrun  out  1  one-clk pulse when a frame starts with no pending sample.

Behaviour:
- Reset values (async, on rst_n low):
  - i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0, sample_ready=1.
  - Divider counter div_cnt=0, frame bit counter f=0, shift register 0, pending empty.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk is registered: it goes 1 when div_cnt==BCLK_DIV/2-1 and goes 0 when div_cnt==BCLK_DIV-1.
  - The cycle where div_cnt==BCLK_DIV-1 is the "fall event". All link outputs update only on fall events, so data is stable for the DAC at the BCLK rising edge.
- Frame counter: f is 0..2*SLOT_W-1 and advances by 1 (with wrap) on each fall event.
- LRCLK: i2s_lrclk <= 1 when the new f is in [SLOT_W, 2*SLOT_W-1], else 0. The change therefore precedes the corresponding slot MSB by one BCLK (I2S one-bit delay).
- Shift register (2*SLOT_W bits):
  - i2s_sdata is the shift register MSB.
  - On each fall event the register shifts left and fills zeros.
  - Exception, the fall event where f goes 0->1 (frame load): load {left, (SLOT_W-DATA_W) zeros, right, (SLOT_W-DATA_W) zeros}. Left MSB appears at f=1; right MSB appears at f=SLOT_W+1.
- Pending buffer and handshake:
  - A transfer writes the pending register; sample_ready then goes 0 the next cycle.
  - A frame load consumes pending and sample_ready goes 1 the next cycle.
  - Frame load with pending empty: load all-zero data and pulse underrun for 1 clk in that same cycle.
  - Transfer and load in the same cycle with pending empty: the load is an underrun; the transferred sample goes to pending for the next frame.
  - Transfer with pending full cannot occur, because ready is 0.
- Latency:
  - A sample accepted before a frame-load fall event: its left MSB is on i2s_sdata from that event.
  - Worst case is one full frame (2*SLOT_W*BCLK_DIV clk) plus 1 clk.
- enable low:
  - div_cnt, f and the shift register return to reset values and outputs drive reset values next cycle.
  - The pending buffer and handshake stay operational.
  - When enable rises, the first frame load occurs at the first fall event (f 0->1).
- enable falling mid-frame truncates the frame. The consumed sample is not replayed.
- Arithmetic: no scaling. Samples pass bit-exact; padding bits are 0.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_HOLD_EN.
- Defined: on an underrun, the frame load repeats the last loaded left/right pair (zeros if none since reset). The underrun pulse is still asserted.
- Undefined: on an underrun, zeros are loaded as specified above.

Decomposition:
- Shared package audio_pkg holds:
  - constant AUDIO_DATA_W=24;
  - typedef audio_sample_t (signed [AUDIO_DATA_W-1:0]);
  - typedef stereo_frame_t (struct left/right).
- Sub-module i2s_clkgen contains div_cnt, f, i2s_bclk, i2s_lrclk generation, and outputs fall_evt and frame_load strobes. The top level keeps the pending buffer, shift register and underrun logic.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> all outputs match reset values immediately; sample_ready=1.
- Single frame (defaults): send L=24'h800001, R=24'h7FFFFE before first load -> sdata bits f=1..24 = 100...001, f=25..32 = 0; lrclk=1 from f=32; bits f=33..56 = 0111...1110; BCLK period = 4 clk.
- Back-to-back stream: present a new pair each frame -> no underrun for 100 frames; decoded samples equal inputs in order; ready low from acceptance until next load.
- Underrun: no sample before the second load -> underrun pulses once; frame 2 sdata all 0 (or repeats frame 1 with I2S_TX_UNDERRUN_HOLD_EN).
- Simultaneous transfer and load with pending empty -> underrun=1 that cycle; sample appears in the following frame.
- enable dropped at f=10 then restored -> bclk/lrclk/sdata held at 0; pending kept; restart outputs that pending sample at f=1.
